// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide, big-endian instruction memory port.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running 32-bit sum of written words.
module instr_mem_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_BYTES = 116,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        word_count,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [1:0]        idx_q, idx_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        count_q, count_d;
    logic              cpu_hold_q, cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    // Last byte of the next word must land inside memory; one extra bit prevents wrap.
    logic [ADDR_W:0] end_addr;
    logic            word_fits;
    assign end_addr  = {1'b0, addr_q} + (ADDR_W+1)'(3);
    assign word_fits = end_addr <= (ADDR_W+1)'(MEM_BYTES - 1);

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        last_d      = last_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        count_d     = count_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    addr_d     = ADDR_W'(BASE_ADDR);
                    mem_addr_d = ADDR_W'(BASE_ADDR);
                    err_d      = 1'b0;
                    count_d    = 8'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 32'd0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (word_fits) begin
                        state_d     = S_WRITE;
                        word_d      = in_word;
                        last_d      = in_last;
                        idx_d       = 2'd0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = in_word[31:24];
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (idx_q != 2'd3) begin
                    idx_d       = idx_q + 2'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q + ADDR_W'(idx_q + 2'd1);
                    mem_wdata_d = byte_of(word_q, idx_q + 2'd1);
                end else begin
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + word_q;
`endif
                    state_d = last_q ? S_DONE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the upcoming state.
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        cpu_hold_d = !(done_d && !err_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= ADDR_W'(BASE_ADDR);
            word_q      <= 32'd0;
            last_q      <= 1'b0;
            idx_q       <= 2'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(BASE_ADDR);
            mem_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= 8'd0;
            cpu_hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
            cpu_hold_q  <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = count_q;
    assign cpu_hold   = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench for instr_mem_loader; expected memory image is rebuilt
// from the accepted word list by byte arithmetic.
module tb_instr_mem_loader;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned MEM_BYTES = 116;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last;
    logic [31:0]       in_word;
    logic              in_ready, mem_we, busy, done, err, cpu_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    instr_mem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_word(in_word),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .word_count(word_count),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0] wa[$];
    logic [7:0]        wd[$];
    int                max_addr = 0;

    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        wa.delete();
        wd.delete();
        max_addr = 0;
    endtask

    task automatic send(input logic [31:0] w, input logic last, input bit drop_valid);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        for (int k = 0; k < 40 && !got; k++) begin
            if (in_ready === 1'b1) got = 1'b1;
            tick();
        end
        if (!got) check("accept_timeout", 64'(0), 64'(1));
        if (drop_valid || !got) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && done !== 1'b1; k++) tick();
        check("done_seen", 64'(done), 64'(1));
    endtask

    // Expected write log: word i occupies bytes 4i..4i+3, most significant byte first.
    task automatic check_image(input string tag, input logic [31:0] wq[$], input int n);
        check({tag, "_nbytes"}, 64'(wa.size()), 64'(4 * n));
        for (int j = 0; j < 4 * n && j < wa.size(); j++) begin
            check({tag, "_addr"}, 64'(wa[j]), 64'(j));
            check({tag, "_data"}, 64'(wd[j]), 64'(8'(wq[j / 4] >> (24 - 8 * (j % 4)))));
        end
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] sum;
        int lows, n;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_word = 32'd0;
        tick(); tick();
        // Reset values
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_count", 64'(word_count), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        reset = 1'b0;
        tick();
        check("idle_in_ready", 64'(in_ready), 64'(0));

        // Single word with last
        do_start();
        check("load_in_ready", 64'(in_ready), 64'(1));
        check("load_busy", 64'(busy), 64'(1));
        send(32'h8C220004, 1'b1, 1'b1);
        check("first_we", 64'(mem_we), 64'(1));
        check("first_addr", 64'(mem_addr), 64'(0));
        check("first_data", 64'(mem_wdata), 64'(8'h8C));
        wait_done();
        wq = {32'h8C220004};
        check_image("one", wq, 1);
        check("one_count", 64'(word_count), 64'(1));
        check("one_err", 64'(err), 64'(0));
        check("one_cpu_hold", 64'(cpu_hold), 64'(0));
        check("one_busy", 64'(busy), 64'(0));

        // Back-to-back words with valid held
        do_start();
        check("restart_done", 64'(done), 64'(0));
        check("restart_count", 64'(word_count), 64'(0));
        send(32'h11223344, 1'b0, 1'b0);
        in_word = 32'h55667788;
        in_last = 1'b1;
        lows = 0;
        for (int k = 0; k < 20 && in_ready !== 1'b1; k++) begin
            lows++;
            tick();
        end
        check("ready_gap", 64'(lows), 64'(4));
        send(32'h55667788, 1'b1, 1'b1);
        wait_done();
        wq = {32'h11223344, 32'h55667788};
        check_image("two", wq, 2);
        check("two_count", 64'(word_count), 64'(2));

        // Random images of random length
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 8);
            wq.delete();
            sum = 32'd0;
            do_start();
            for (int i = 0; i < n; i++) begin
                wq.push_back($urandom);
                sum = sum + wq[i];
                send(wq[i], (i == n - 1), 1'b1);
            end
            wait_done();
            check_image("rnd", wq, n);
            check("rnd_count", 64'(word_count), 64'(n));
            check("rnd_err", 64'(err), 64'(0));
            check("rnd_cpu_hold", 64'(cpu_hold), 64'(0));
`ifdef LOADER_CHECKSUM_EN
            check("rnd_checksum", 64'(checksum), 64'(sum));
`endif
        end

        // Overflow: 30 words, only MEM_BYTES/4 fit
        wq.delete();
        do_start();
        for (int i = 0; i < 30; i++) begin
            wq.push_back($urandom);
            send(wq[i], 1'b0, 1'b1);
        end
        wait_done();
        check_image("ovf", wq, MEM_BYTES / 4);
        check("ovf_err", 64'(err), 64'(1));
        check("ovf_count", 64'(word_count), 64'(MEM_BYTES / 4));
        check("ovf_cpu_hold", 64'(cpu_hold), 64'(1));
        check("ovf_max_addr", 64'(max_addr), 64'(MEM_BYTES - 1));
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check("done_ignores_valid", 64'(wa.size()), 64'(MEM_BYTES));

        // Reset after the second byte of a word
        do_start();
        send($urandom, 1'b0, 1'b1);
        send($urandom, 1'b0, 1'b1);
        check("pre_rst_count", 64'(word_count), 64'(1));
        tick();
        check("pre_rst_addr", 64'(mem_addr), 64'(5));
        reset = 1'b1;
        #1;
        check("mid_rst_we", 64'(mem_we), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_count", 64'(word_count), 64'(0));
        check("mid_rst_cpu_hold", 64'(cpu_hold), 64'(1));
        tick();
        reset = 1'b0;
        wa.delete();
        for (int k = 0; k < 8; k++) tick();
        check("post_rst_no_we", 64'(wa.size()), 64'(0));
        check("post_rst_idle", 64'(busy | in_ready | done), 64'(0));

`ifdef LOADER_CHECKSUM_EN
        do_start();
        send(32'h00000001, 1'b0, 1'b1);
        send(32'h00000002, 1'b0, 1'b1);
        send(32'hFFFFFFFF, 1'b1, 1'b1);
        wait_done();
        check("csum_wrap", 64'(checksum), 64'(32'h00000002));
        do_start();
        check("csum_clear", 64'(checksum), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
